instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_if.sv | 54 +++++
 rtl/instr_mem_loader.sv | 120 ++++++++++++
 tb/tb_instr_mem_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - fetch, program-load and status signals of the instruction memory loader
//
// Purpose: bundles every instr_mem_loader signal except clk/reset.
// Ports (as seen from the loader, modport slave):
//   IMAddress   in  16  fetch address from the fetch unit
//   Instruction out 16  instruction word at IMAddress (NOP while loading / out of range)
//   load_valid  in   1  load_data/load_last carry a program word
//   load_data   in  16  program word to store
//   load_last   in   1  final word of the program image
//   load_ready  out  1  a program word is accepted this cycle
//   reload      in   1  request a return to loading from address 0
//   cpu_hold    out  1  fetch unit must not advance the PC
//   word_count  out 16  words written in the current/last load
//   addr_err    out  1  sticky out-of-range fetch flag
// The master modport is the mirror image, used by whatever drives the loader.

interface instr_mem_loader_if;
    logic [15:0] IMAddress;
    logic [15:0] Instruction;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        reload;
    logic        cpu_hold;
    logic [15:0] word_count;
    logic        addr_err;

    modport slave (
        input  IMAddress,
        input  load_valid,
        input  load_data,
        input  load_last,
        input  reload,
        output Instruction,
        output load_ready,
        output cpu_hold,
        output word_count,
        output addr_err
    );

    modport master (
        output IMAddress,
        output load_valid,
        output load_data,
        output load_last,
        output reload,
        input  Instruction,
        input  load_ready,
        input  cpu_hold,
        input  word_count,
        input  addr_err
    );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - instruction memory that is filled by a word stream, then serves fetches
//
// Purpose: in LOAD, program words are written sequentially from address 0 while the CPU is held;
// in RUN, the memory is read combinationally at IMAddress and the CPU runs.
// Ports:
//   clk    in  1  single clock, rising edge
//   reset  in  1  synchronous active-high reset (state/counters only, memory is not cleared)
//   bus    slave modport of instr_mem_loader_if (fetch, load stream, reload, status)
// Parameters:
//   DEPTH     number of 16-bit words, power of two, 2..65536
//   NOP_WORD  instruction returned while loading or for out-of-range fetches

module instr_mem_loader #(
    parameter int          DEPTH    = 256,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_mem_loader_if.slave     bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]   word_count_q, word_count_d;
    logic          addr_err_q, addr_err_d;
    logic          mem_we;

    // No reset on the array: contents survive reset and reload.
    logic [15:0]   mem [DEPTH];

    logic          in_range;
    logic [AW-1:0] rd_addr;

    // Compare in 32 bits so DEPTH=65536 does not overflow the 16-bit address space.
    assign in_range = ({16'd0, bus.IMAddress} < 32'(DEPTH));
    assign rd_addr  = bus.IMAddress[AW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // A write coinciding with reset is dropped so that a reset mid-load leaves no trace
    // beyond the words already accepted.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[wr_ptr_q] <= bus.load_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        addr_err_d   = addr_err_q;
        mem_we       = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                if (bus.reload) begin
                    // Reload wins over a simultaneous transfer.
                    wr_ptr_d     = '0;
                    word_count_d = '0;
                end else if (bus.load_valid) begin
                    mem_we       = 1'b1;
                    word_count_d = word_count_q + 16'd1;
                    if (bus.load_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
                        // Leaving LOAD; the pointer stays put rather than wrapping.
                        state_d = S_RUN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end
            S_RUN: begin
                if (bus.reload) begin
                    state_d      = S_LOAD;
                    wr_ptr_d     = '0;
                    word_count_d = '0;
                    addr_err_d   = 1'b0;
                end else if (!in_range) begin
                    addr_err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Handshake/hold decode only from the registered state: no path from load_valid.
    assign bus.load_ready = (state_q == S_LOAD);
    assign bus.cpu_hold   = (state_q == S_LOAD);
    assign bus.word_count = word_count_q;
    assign bus.addr_err   = addr_err_q;

    always_comb begin
        bus.Instruction = NOP_WORD;
        if ((state_q == S_RUN) && in_range) begin
            bus.Instruction = mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - two loader instances (DEPTH 256 and 4) on shared stimulus vs a word-level model

module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] im_addr;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        reload;

    always #5 clk = ~clk;

    instr_mem_loader_if bus_a ();
    instr_mem_loader_if bus_b ();

    assign bus_a.IMAddress  = im_addr;
    assign bus_a.load_valid = load_valid;
    assign bus_a.load_data  = load_data;
    assign bus_a.load_last  = load_last;
    assign bus_a.reload     = reload;
    assign bus_b.IMAddress  = im_addr;
    assign bus_b.load_valid = load_valid;
    assign bus_b.load_data  = load_data;
    assign bus_b.load_last  = load_last;
    assign bus_b.reload     = reload;

    instr_mem_loader #(.DEPTH(256), .NOP_WORD(16'h0000)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    instr_mem_loader #(.DEPTH(4), .NOP_WORD(16'h0000)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: per instance, running flag, words written, sticky error, and written words by address.
    bit          m_valid = 1'b0;
    bit          m_run [2];
    int          m_cnt [2];
    bit          m_err [2];
    logic [15:0] m_mem [int];

    function automatic int depth_of(input int i);
        return (i == 0) ? 256 : 4;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int d;
        if (reset) begin
            m_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 1'b0;
                m_cnt[i] = 0;
                m_err[i] = 1'b0;
            end
            return;
        end
        if (!m_valid) return;
        for (int i = 0; i < 2; i++) begin
            d = depth_of(i);
            if (!m_run[i]) begin
                if (reload) begin
                    m_cnt[i] = 0;
                end else if (load_valid) begin
                    m_mem[i * 65536 + m_cnt[i]] = load_data;
                    m_cnt[i] = m_cnt[i] + 1;
                    if (load_last || m_cnt[i] == d) m_run[i] = 1'b1;
                end
            end else if (reload) begin
                m_run[i] = 1'b0;
                m_cnt[i] = 0;
                m_err[i] = 1'b0;
            end else if (int'(im_addr) >= d) begin
                m_err[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_step();
        logic [15:0] instr, wc;
        logic        rdy, hold, err;
        int          key;
        if (!m_valid) return;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                instr = bus_a.Instruction; wc = bus_a.word_count;
                rdy = bus_a.load_ready; hold = bus_a.cpu_hold; err = bus_a.addr_err;
            end else begin
                instr = bus_b.Instruction; wc = bus_b.word_count;
                rdy = bus_b.load_ready; hold = bus_b.cpu_hold; err = bus_b.addr_err;
            end
            chk($sformatf("m%0d_load_ready", i), 16'(rdy),  16'(!m_run[i]));
            chk($sformatf("m%0d_cpu_hold", i),   16'(hold), 16'(!m_run[i]));
            chk($sformatf("m%0d_word_count", i), wc,        16'(m_cnt[i]));
            chk($sformatf("m%0d_addr_err", i),   16'(err),  16'(m_err[i]));
            if (!m_run[i] || int'(im_addr) >= depth_of(i)) begin
                chk($sformatf("m%0d_instr_nop", i), instr, 16'h0000);
            end else begin
                key = i * 65536 + int'(im_addr);
                if (m_mem.exists(key)) chk($sformatf("m%0d_instr", i), instr, m_mem[key]);
            end
        end
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) compare_step();

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        int sel;
        reset = 1'b1; im_addr = '0; load_valid = 1'b0; load_data = '0; load_last = 1'b0; reload = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_ready",  16'(bus_a.load_ready), 16'd1);
        chk("rst_hold",   16'(bus_a.cpu_hold),   16'd1);
        chk("rst_instr",  bus_a.Instruction,     16'h0000);
        chk("rst_count",  bus_a.word_count,      16'd0);
        chk("rst_err",    16'(bus_a.addr_err),   16'd0);

        // Three-word image, last on the third.
        load(16'hA001, 1'b0);
        load(16'hA002, 1'b0);
        load(16'hA003, 1'b1);
        im_addr = 16'd1;
        #1;
        chk("img3_hold",   16'(bus_a.cpu_hold), 16'd0);
        chk("img3_count",  bus_a.word_count,    16'd3);
        chk("img3_instr",  bus_a.Instruction,   16'hA002);
        chk("img3_instr_b", bus_b.Instruction,  16'hA002);
        tick();

        // Out-of-range fetch on the 256-deep instance.
        im_addr = 16'h0100;
        #1;
        chk("oor_instr",   bus_a.Instruction,   16'h0000);
        chk("oor_err_pre", 16'(bus_a.addr_err), 16'd0);
        tick();
        chk("oor_err",     16'(bus_a.addr_err), 16'd1);
        im_addr = 16'd0;
        tick();
        chk("oor_sticky",  16'(bus_a.addr_err), 16'd1);
        chk("oor_instr0",  bus_a.Instruction,   16'hA001);

        // Reload from RUN, then a one-word image.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        #1;
        chk("rl_hold",  16'(bus_a.cpu_hold), 16'd1);
        chk("rl_err",   16'(bus_a.addr_err), 16'd0);
        chk("rl_count", bus_a.word_count,    16'd0);
        load(16'hBEEF, 1'b1);
        im_addr = 16'd0;
        #1;
        chk("rl_mem0", bus_a.Instruction, 16'hBEEF);
        im_addr = 16'd1;
        #1;
        chk("rl_mem1", bus_a.Instruction, 16'hA002);
        tick();

        // Fill the 4-deep instance without load_last.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        for (int k = 0; k < 4; k++) load(16'hC000 + 16'(k), 1'b0);
        #1;
        chk("full_hold_b",  16'(bus_b.cpu_hold), 16'd0);
        chk("full_count_b", bus_b.word_count,    16'd4);
        chk("full_hold_a",  16'(bus_a.cpu_hold), 16'd1);
        load(16'hC004, 1'b0);
        #1;
        chk("full_ignored_b", bus_b.word_count, 16'd4);
        chk("full_count_a",   bus_a.word_count, 16'd5);
        im_addr = 16'd3;
        #1;
        chk("full_last_b", bus_b.Instruction, 16'hC003);
        im_addr = 16'd4;
        #1;
        chk("full_oor_b", bus_b.Instruction, 16'h0000);
        tick();
        chk("full_err_b", 16'(bus_b.addr_err), 16'd1);

        // Transfer and reload in the same LOAD cycle.
        load_valid = 1'b1; load_data = 16'hDEAD; reload = 1'b1;
        tick();
        load_valid = 1'b0; reload = 1'b0;
        #1;
        chk("rlx_count_a", bus_a.word_count,    16'd0);
        chk("rlx_hold_a",  16'(bus_a.cpu_hold), 16'd1);
        chk("rlx_err_b",   16'(bus_b.addr_err), 16'd0);

        // Reset after two of five words.
        load(16'hD000, 1'b0);
        load(16'hD001, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_count", bus_a.word_count,    16'd0);
        chk("mid_rst_hold",  16'(bus_a.cpu_hold), 16'd1);
        load(16'hD005, 1'b1);
        im_addr = 16'd0;
        #1;
        chk("mid_rst_mem0", bus_a.Instruction, 16'hD005);
        im_addr = 16'd1;
        #1;
        chk("mid_rst_mem1", bus_a.Instruction, 16'hD001);
        tick();

        // Random traffic checked every cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            load_valid = ($urandom_range(0, 1) == 1);
            load_data  = 16'($urandom);
            load_last  = ($urandom_range(0, 7) == 0);
            reload     = ($urandom_range(0, 31) == 0);
            reset      = ($urandom_range(0, 255) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       im_addr = 16'($urandom_range(0, 7));
            else if (sel < 9)  im_addr = 16'($urandom_range(0, 300));
            else               im_addr = 16'($urandom);
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0; reload = 1'b0; reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
